bit_stream_serializer: RTL and testbench

Parallel-to-serial front end that turns handshaked WIDTH-bit words into the one-bit-per-clock stream consumed by `sequence_detector` on its `data_in` input. It has a one-word holding register so a producer can queue the next word while the current one shifts out, which gives gap-free back-to-back streaming. A configurable idle gap can be inserted between words. Markers tell the detector side which bits are payload and where each word ends.

---
 rtl/bit_stream_serializer_if.sv | 29 ++
 rtl/bit_stream_serializer.sv | 126 ++++++++++++
 tb/tb_bit_stream_serializer.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/bit_stream_serializer_if.sv
// Word handshake on the producer side and the serial stream toward the detector.
interface bit_stream_serializer_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             data_out;
    logic             out_valid;
    logic             word_done;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  data_out,
        input  out_valid,
        input  word_done
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output data_out,
        output out_valid,
        output word_done
    );
endinterface

// File: rtl/bit_stream_serializer.sv
// Parallel-to-serial front end with a one-word holding register and an optional
// idle gap between words.
//
// state | meaning
// IDLE  | nothing shifting, data_out = IDLE_BIT
// SHIFT | one payload bit per cycle
// GAP   | GAP_CYCLES idle cycles after a word
module bit_stream_serializer #(
    parameter int WIDTH      = 8,
    parameter bit MSB_FIRST  = 1'b1,
    parameter int GAP_CYCLES = 0,
    parameter bit IDLE_BIT   = 1'b0
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    bit_stream_serializer_if.slave s_bus,
    output logic                   o_busy
);
    localparam int            CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
    localparam logic [7:0]    GAP_LOAD = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_shift;
    logic [CW-1:0]    r_bit_cnt;
    logic [7:0]       r_gap_cnt;
    logic [WIDTH-1:0] r_hold;
    logic             r_hold_full;

    logic             w_accept;
    logic             w_last_bit;
    logic             w_gap_last;
    logic             w_free;
    logic             w_load;
    logic [WIDTH-1:0] w_load_data;
    logic             w_shifting;

    assign w_shifting  = (r_state == ST_SHIFT);
    assign w_accept    = s_bus.in_valid && !r_hold_full;
    assign w_last_bit  = w_shifting && (r_bit_cnt == LAST_BIT);
    assign w_gap_last  = (r_state == ST_GAP) && (r_gap_cnt == 8'd0);
    assign w_free      = (r_state == ST_IDLE) || (w_last_bit && (GAP_CYCLES == 0)) || w_gap_last;
    assign w_load      = w_free && (r_hold_full || w_accept);
    // A full holding register blocks accepts, so it always wins the shifter.
    assign w_load_data = r_hold_full ? r_hold : s_bus.in_data;

    always_comb begin
        s_bus.in_ready  = !r_hold_full;
        s_bus.out_valid = w_shifting;
        s_bus.data_out  = IDLE_BIT;
        if (w_shifting) begin
            s_bus.data_out = MSB_FIRST ? r_shift[WIDTH-1] : r_shift[0];
        end
        s_bus.word_done = w_last_bit;
        o_busy          = (r_state != ST_IDLE) || r_hold_full;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_hold_full <= 1'b0;
            r_hold      <= '0;
        end else if (w_free && r_hold_full) begin
            r_hold_full <= 1'b0;
        end else if (w_accept && !w_free) begin
            r_hold      <= s_bus.in_data;
            r_hold_full <= 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= ST_IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_gap_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_load) begin
                        r_state   <= ST_SHIFT;
                        r_shift   <= w_load_data;
                        r_bit_cnt <= '0;
                    end
                end
                ST_SHIFT: begin
                    if (w_last_bit) begin
                        if (GAP_CYCLES > 0) begin
                            r_state   <= ST_GAP;
                            r_gap_cnt <= GAP_LOAD;
                        end else if (w_load) begin
                            r_shift   <= w_load_data;
                            r_bit_cnt <= '0;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        if (MSB_FIRST) begin
                            r_shift <= {r_shift[WIDTH-2:0], 1'b0};
                        end else begin
                            r_shift <= {1'b0, r_shift[WIDTH-1:1]};
                        end
                    end
                end
                ST_GAP: begin
                    if (w_gap_last) begin
                        if (w_load) begin
                            r_state   <= ST_SHIFT;
                            r_shift   <= w_load_data;
                            r_bit_cnt <= '0;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_gap_cnt <= r_gap_cnt - 8'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bit_stream_serializer.sv
// Directed and randomized checks of the serializer: MSB-first/no-gap and LSB-first/gap builds.
module tb_bit_stream_serializer;
    logic clk;
    logic reset;
    logic busy_a;
    logic busy_b;
    int   errors = 0;
    int   checks = 0;

    bit_stream_serializer_if #(.WIDTH(8)) ifa ();
    bit_stream_serializer_if #(.WIDTH(8)) ifb ();

    bit_stream_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP_CYCLES(0), .IDLE_BIT(1'b0)) dut_a (
        .i_clk(clk), .i_reset(reset), .s_bus(ifa.slave), .o_busy(busy_a)
    );
    bit_stream_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .GAP_CYCLES(2), .IDLE_BIT(1'b0)) dut_b (
        .i_clk(clk), .i_reset(reset), .s_bus(ifb.slave), .o_busy(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Bit i (0 = first sent) of word w for a given bit order.
    function automatic logic bit_of(input logic [7:0] w, input int i, input bit msb_first);
        return msb_first ? w[7 - i] : w[i];
    endfunction

    initial begin
        logic [7:0] w0;
        logic [7:0] w1;
        logic [7:0] q[$];
        logic [7:0] asm_word;
        logic [7:0] exp_word;
        int         acc;
        int         rcv;
        int         nb;
        int         cyc;

        reset = 1'b1;
        ifa.in_valid = 1'b0; ifa.in_data = '0;
        ifb.in_valid = 1'b0; ifb.in_data = '0;
        step(); step();
        reset = 1'b0;

        for (int i = 0; i < 5; i++) begin
            step();
            chk("idle_data_a", 32'(ifa.data_out), 32'(1'b0));
            chk("idle_valid_a", 32'(ifa.out_valid), 32'(1'b0));
            chk("idle_busy_a", 32'(busy_a), 32'(1'b0));
            chk("idle_ready_a", 32'(ifa.in_ready), 32'(1'b1));
            chk("idle_valid_b", 32'(ifb.out_valid), 32'(1'b0));
        end

        // Single word, MSB first.
        w0 = 8'hAA;
        ifa.in_valid = 1'b1; ifa.in_data = w0;
        step();
        ifa.in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("single_bit", 32'(ifa.data_out), 32'(bit_of(w0, i, 1'b1)));
            chk("single_valid", 32'(ifa.out_valid), 32'(1'b1));
            chk("single_done", 32'(ifa.word_done), 32'(i == 7));
            step();
        end
        chk("single_end_valid", 32'(ifa.out_valid), 32'(1'b0));
        chk("single_end_busy", 32'(busy_a), 32'(1'b0));

        // Back-to-back, second word held while the first shifts.
        w0 = 8'hAA; w1 = 8'hB5;
        ifa.in_valid = 1'b1; ifa.in_data = w0;
        step();
        ifa.in_data = w1;
        for (int i = 0; i < 16; i++) begin
            chk("b2b_bit", 32'(ifa.data_out), 32'(i < 8 ? bit_of(w0, i, 1'b1) : bit_of(w1, i - 8, 1'b1)));
            chk("b2b_valid", 32'(ifa.out_valid), 32'(1'b1));
            chk("b2b_done", 32'(ifa.word_done), 32'(i == 7 || i == 15));
            chk("b2b_ready", 32'(ifa.in_ready), 32'(!(i >= 1 && i <= 7)));
            step();
            if (i == 0) ifa.in_valid = 1'b0;
        end
        chk("b2b_end_valid", 32'(ifa.out_valid), 32'(1'b0));

        // LSB first with a two-cycle gap.
        w0 = 8'h01; w1 = 8'h80;
        ifb.in_valid = 1'b1; ifb.in_data = w0;
        step();
        ifb.in_data = w1;
        for (int i = 0; i < 18; i++) begin
            if (i < 8) begin
                chk("gap_bit0", 32'(ifb.data_out), 32'(bit_of(w0, i, 1'b0)));
                chk("gap_valid0", 32'(ifb.out_valid), 32'(1'b1));
            end else if (i < 10) begin
                chk("gap_idle_bit", 32'(ifb.data_out), 32'(1'b0));
                chk("gap_idle_valid", 32'(ifb.out_valid), 32'(1'b0));
                chk("gap_busy", 32'(busy_b), 32'(1'b1));
            end else begin
                chk("gap_bit1", 32'(ifb.data_out), 32'(bit_of(w1, i - 10, 1'b0)));
                chk("gap_valid1", 32'(ifb.out_valid), 32'(1'b1));
            end
            chk("gap_done", 32'(ifb.word_done), 32'(i == 7 || i == 17));
            step();
            if (i == 0) ifb.in_valid = 1'b0;
        end
        chk("gap_end_valid", 32'(ifb.out_valid), 32'(1'b0));

        // Reset in the middle of a word with another word held.
        ifa.in_valid = 1'b1; ifa.in_data = 8'hFF;
        step();
        ifa.in_data = 8'h0F;
        step();
        ifa.in_valid = 1'b0;
        chk("rst_held_ready", 32'(ifa.in_ready), 32'(1'b0));
        step(); step();
        reset = 1'b1;
        step();
        chk("rst_valid", 32'(ifa.out_valid), 32'(1'b0));
        chk("rst_busy", 32'(busy_a), 32'(1'b0));
        chk("rst_ready", 32'(ifa.in_ready), 32'(1'b1));
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            chk("rst_quiet_valid", 32'(ifa.out_valid), 32'(1'b0));
            chk("rst_quiet_data", 32'(ifa.data_out), 32'(1'b0));
        end
        w0 = 8'h3C;
        ifa.in_valid = 1'b1; ifa.in_data = w0;
        step();
        ifa.in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("post_rst_bit", 32'(ifa.data_out), 32'(bit_of(w0, i, 1'b1)));
            chk("post_rst_done", 32'(ifa.word_done), 32'(i == 7));
            step();
        end

        // Random producer; reassemble the stream and match against accepted order.
        acc = 0; rcv = 0; nb = 0; cyc = 0; asm_word = '0;
        while ((acc < 200 || q.size() > 0) && cyc < 20000) begin
            if (acc < 200) begin
                ifa.in_valid = ($urandom_range(0, 2) != 0);
                ifa.in_data  = 8'($urandom);
            end else begin
                ifa.in_valid = 1'b0;
            end
            if (ifa.in_valid && ifa.in_ready) begin
                q.push_back(ifa.in_data);
                acc++;
            end
            step();
            cyc++;
            if (ifa.out_valid) begin
                asm_word = {asm_word[6:0], ifa.data_out};
                nb++;
            end
            if (ifa.word_done) begin
                rcv++;
                chk("rand_bits_per_word", 32'(nb), 32'(8));
                chk("rand_word_expected", 32'(q.size() > 0), 32'(1'b1));
                if (q.size() > 0) begin
                    exp_word = q.pop_front();
                    chk("rand_word", 32'(asm_word), 32'(exp_word));
                end
                nb = 0;
            end
        end
        ifa.in_valid = 1'b0;
        chk("rand_timeout", 32'(cyc < 20000), 32'(1'b1));
        chk("rand_received", 32'(rcv), 32'(200));
        chk("rand_queue_left", 32'(q.size()), 32'(0));
        step(); step();
        chk("rand_end_busy", 32'(busy_a), 32'(1'b0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
